// File: rtl/i2c_init_seq.sv
// i2c_init_seq: walks a codec configuration table and programs each word through an I2C driver's local bus.
// Define I2C_INIT_SEQ_RETRY_EN to retry a NACKed entry up to P_MAX_RETRY times before flagging err_oh.
module i2c_init_seq #(
    parameter int         P_NUM_ENTRIES  = 11,
    parameter logic [7:0] P_DEV_ADDR     = 8'h34,
    parameter logic [7:0] P_CLK_DIV      = 8'd125,
    parameter logic [7:0] P_STATUS_ADDR  = 8'h00,
    parameter logic [7:0] P_ADDR_ADDR    = 8'h01,
    parameter logic [7:0] P_DATA_ADDR    = 8'h02,
    parameter logic [7:0] P_CLK_DIV_ADDR = 8'h03,
    parameter int         P_MAX_RETRY    = 3
) (
    input  logic        clk_ir,
    input  logic        rst_il,
    input  logic        start_ih,
    output logic [7:0]  tbl_addr_od,
    input  logic [15:0] tbl_data_ih,
    output logic        lb_rd_en_od,
    output logic        lb_wr_en_od,
    output logic [7:0]  lb_addr_od,
    output logic [15:0] lb_wr_data_od,
    input  logic        lb_rd_valid_ih,
    input  logic [15:0] lb_rd_data_ih,
    output logic        busy_oh,
    output logic        done_oh,
    output logic        err_oh
);
    typedef enum logic [3:0] {IDLE, CFG, FETCH, WR_ADDR, WR_DATA, TRIG, GAP, POLL, WAIT, NEXT, FIN} state_t;
    state_t      state;
    logic [1:0]  gap_cnt;
    logic [15:0] word;
    logic        unused_bits;
`ifdef I2C_INIT_SEQ_RETRY_EN
    logic [7:0]  retry_cnt;
`endif
    assign unused_bits = ^{lb_rd_data_ih[15:2], P_MAX_RETRY};
    // Bus strobes are set on entry to the state that owns them, so they are high exactly while in it.
    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            state         <= IDLE;
            gap_cnt       <= '0;
            word          <= '0;
            tbl_addr_od   <= '0;
            lb_rd_en_od   <= 1'b0;
            lb_wr_en_od   <= 1'b0;
            lb_addr_od    <= '0;
            lb_wr_data_od <= '0;
            busy_oh       <= 1'b0;
            done_oh       <= 1'b0;
            err_oh        <= 1'b0;
`ifdef I2C_INIT_SEQ_RETRY_EN
            retry_cnt     <= '0;
`endif
        end else begin
            lb_wr_en_od <= 1'b0;
            lb_rd_en_od <= 1'b0;
            done_oh     <= 1'b0;
            case (state)
                IDLE: if (start_ih) begin
                    state         <= CFG;
                    busy_oh       <= 1'b1;
                    err_oh        <= 1'b0;
                    tbl_addr_od   <= '0;
                    lb_wr_en_od   <= 1'b1;
                    lb_addr_od    <= P_CLK_DIV_ADDR;
                    lb_wr_data_od <= {8'h00, P_CLK_DIV};
                end
                CFG: state <= FETCH;
                FETCH: begin
                    word          <= tbl_data_ih;
                    state         <= WR_ADDR;
                    lb_wr_en_od   <= 1'b1;
                    lb_addr_od    <= P_ADDR_ADDR;
                    lb_wr_data_od <= {8'h00, P_DEV_ADDR};
                end
                WR_ADDR: begin
                    state         <= WR_DATA;
                    lb_wr_en_od   <= 1'b1;
                    lb_addr_od    <= P_DATA_ADDR;
                    lb_wr_data_od <= word;
                end
                WR_DATA: begin
                    state         <= TRIG;
                    lb_wr_en_od   <= 1'b1;
                    lb_addr_od    <= P_STATUS_ADDR;
                    lb_wr_data_od <= 16'h0000;
                end
                TRIG: state <= GAP;
                GAP: begin
                    gap_cnt <= gap_cnt + 2'd1;
                    if (gap_cnt == 2'd3) begin
                        state       <= POLL;
                        lb_rd_en_od <= 1'b1;
                        lb_addr_od  <= P_STATUS_ADDR;
                    end
                end
                POLL: state <= WAIT;
                WAIT: if (lb_rd_valid_ih) begin
                    if (lb_rd_data_ih[0])
                        state <= GAP;
                    else if (!lb_rd_data_ih[1])
                        state <= NEXT;
`ifdef I2C_INIT_SEQ_RETRY_EN
                    else if (retry_cnt < 8'(P_MAX_RETRY)) begin
                        retry_cnt     <= retry_cnt + 8'd1;
                        state         <= WR_ADDR;
                        lb_wr_en_od   <= 1'b1;
                        lb_addr_od    <= P_ADDR_ADDR;
                        lb_wr_data_od <= {8'h00, P_DEV_ADDR};
                    end
`endif
                    else begin
                        err_oh  <= 1'b1;
                        done_oh <= 1'b1;
                        state   <= FIN;
                    end
                end
                NEXT: begin
`ifdef I2C_INIT_SEQ_RETRY_EN
                    retry_cnt <= '0;
`endif
                    if (tbl_addr_od == 8'(P_NUM_ENTRIES - 1)) begin
                        done_oh <= 1'b1;
                        state   <= FIN;
                    end else begin
                        tbl_addr_od <= tbl_addr_od + 8'd1;
                        state       <= FETCH;
                    end
                end
                FIN: begin
                    busy_oh <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
